// File: rtl/serial_addsub_pkg.sv
// Shared encodings for the bit-serial add/subtract unit.
package serial_addsub_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_CALC = 1'b1
    } state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/serial_addsub_full_adder.sv
// One-bit full adder used as the serial arithmetic slice.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_addsub.sv
// Bit-serial add/subtract: operands captured on a start rising edge, processed
// LSB-first one bit per clock; F/Cout/V are held until the next completion.
module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             CLOCK_50,
    input  logic             RST,
    input  logic             start,
    input  logic [WIDTH-1:0] a0,
    input  logic [WIDTH-1:0] a1,
    input  logic             s,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] F,
    output logic             Cout,
    output logic             V,
    output state_t           dbg_state
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    // Request/response: a rising edge of start while idle launches one
    // operation (busy=1); exactly WIDTH clocks later busy falls and valid rises.
    // Edges seen while busy are dropped; valid stays up until the next launch.
    state_t             state, state_nxt;
    logic               start_q;
    logic               trigger;
    logic               last_bit;
    logic [WIDTH-1:0]   op_a, op_b, res;
    logic               carry;
    logic [CNT_W-1:0]   cnt;
    logic               fa_sum, fa_cout;

    full_adder u_fa (
        .a    (op_a[0]),
        .b    (op_b[0]),
        .cin  (carry),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    always_comb begin
        state_nxt = state;
        trigger   = start & ~start_q;
        last_bit  = (cnt == CNT_W'(WIDTH - 1));
        case (state)
            ST_IDLE: if (trigger)  state_nxt = ST_CALC;
            ST_CALC: if (last_bit) state_nxt = ST_IDLE;
            default:               state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RST) begin
            state   <= ST_IDLE;
            start_q <= 1'b1;
            op_a    <= '0;
            op_b    <= '0;
            res     <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            F       <= '0;
            Cout    <= 1'b0;
            V       <= 1'b0;
            valid   <= 1'b0;
            busy    <= 1'b0;
        end else begin
            start_q <= start;
            state   <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (trigger) begin
                        // Subtract as a0 + ~a1 + 1: the +1 enters as carry-in.
                        op_a  <= a0;
                        op_b  <= (s == OP_SUB) ? ~a1 : a1;
                        carry <= s;
                        cnt   <= '0;
                        res   <= '0;
                        valid <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                ST_CALC: begin
                    op_a  <= op_a >> 1;
                    op_b  <= op_b >> 1;
                    carry <= fa_cout;
                    res   <= {fa_sum, res[WIDTH-1:1]};
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        // carry here is still the carry into the MSB.
                        F     <= {fa_sum, res[WIDTH-1:1]};
                        Cout  <= fa_cout;
                        V     <= carry ^ fa_cout;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_serial_addsub.sv
// Directed self-checking bench for serial_addsub.
module tb_serial_addsub;
    import serial_addsub_pkg::*;

    localparam int W = 4;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] a0, a1;
    logic         s;
    logic         busy, valid, cout, v;
    logic [W-1:0] f;
    state_t       dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] exp_f;
    logic         exp_c, exp_v;

    serial_addsub #(.WIDTH(W)) dut (
        .CLOCK_50  (clk),
        .RST       (rst),
        .start     (start),
        .a0        (a0),
        .a1        (a1),
        .s         (s),
        .busy      (busy),
        .valid     (valid),
        .F         (f),
        .Cout      (cout),
        .V         (v),
        .dbg_state (dbg_state)
    );

    // clock/reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_result(input string tag);
        chk({tag, "_f"},    8'(f),    8'(exp_f));
        chk({tag, "_cout"}, 8'(cout), 8'(exp_c));
        chk({tag, "_v"},    8'(v),    8'(exp_v));
    endtask

    // Launch one operation, check busy/hold during CALC and the result at edge k+W.
    task automatic run_op(input string tag, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic op, input logic [W-1:0] ef, input logic ec, input logic ev);
        @(negedge clk);
        a0 = x; a1 = y; s = op; start = 1'b1;
        tick();
        chk({tag, "_busy_cap"},  8'(busy),  8'd1);
        chk({tag, "_valid_cap"}, 8'(valid), 8'd0);
        @(negedge clk);
        start = 1'b0;
        a0 = $urandom_range(0, 15);
        a1 = $urandom_range(0, 15);
        for (int i = 1; i < W; i++) begin
            tick();
            chk({tag, "_busy_mid"},  8'(busy),  8'd1);
            chk({tag, "_valid_mid"}, 8'(valid), 8'd0);
            chk_result({tag, "_hold"});
        end
        tick();
        exp_f = ef; exp_c = ec; exp_v = ev;
        chk({tag, "_valid_done"}, 8'(valid), 8'd1);
        chk({tag, "_busy_done"},  8'(busy),  8'd0);
        chk_result({tag, "_done"});
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; a0 = '0; a1 = '0; s = 1'b0;
        exp_f = '0; exp_c = 1'b0; exp_v = 1'b0;
        tick();
        tick();
        chk("rst_busy",  8'(busy),  8'd0);
        chk("rst_valid", 8'(valid), 8'd0);
        chk("rst_state", 8'(dbg_state), 8'(ST_IDLE));
        chk_result("rst");
        @(negedge clk);
        rst = 1'b0;
        tick();

        run_op("add_5_3",  4'd5,  4'd3, OP_ADD, 4'd8,  1'b0, 1'b1);
        run_op("sub_7_2",  4'd7,  4'd2, OP_SUB, 4'd5,  1'b1, 1'b0);
        run_op("sub_2_7",  4'd2,  4'd7, OP_SUB, 4'd11, 1'b0, 1'b0);
        run_op("add_15_1", 4'd15, 4'd1, OP_ADD, 4'd0,  1'b1, 1'b0);

        // Re-trigger while busy is ignored; start held high across completion.
        @(negedge clk);
        a0 = 4'd3; a1 = 4'd4; s = OP_ADD; start = 1'b1;
        tick();
        @(negedge clk);
        start = 1'b0;
        tick();
        @(negedge clk);
        a0 = 4'd9; s = OP_SUB; start = 1'b1;
        tick();
        chk("ign_busy", 8'(busy), 8'd1);
        tick();
        tick();
        exp_f = 4'd7; exp_c = 1'b0; exp_v = 1'b0;
        chk("ign_valid", 8'(valid), 8'd1);
        chk_result("ign_done");
        for (int i = 0; i < 3; i++) tick();
        chk("ign_no_retrig_busy",  8'(busy),  8'd0);
        chk("ign_no_retrig_valid", 8'(valid), 8'd1);
        chk_result("ign_no_retrig");
        @(negedge clk);
        start = 1'b0;
        tick();

        // Reset in the middle of CALC, start held high through release.
        run_op("pre_rst", 4'd5, 4'd3, OP_ADD, 4'd8, 1'b0, 1'b1);
        @(negedge clk);
        a0 = 4'd7; a1 = 4'd2; s = OP_SUB; start = 1'b1;
        tick();
        tick();
        @(negedge clk);
        rst = 1'b1;
        tick();
        exp_f = '0; exp_c = 1'b0; exp_v = 1'b0;
        chk("midrst_busy",  8'(busy),  8'd0);
        chk("midrst_valid", 8'(valid), 8'd0);
        chk("midrst_state", 8'(dbg_state), 8'(ST_IDLE));
        chk_result("midrst");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("held_busy",  8'(busy),  8'd0);
        chk("held_valid", 8'(valid), 8'd0);
        chk_result("held");
        @(negedge clk);
        start = 1'b0;
        tick();
        run_op("after_rst", 4'd7, 4'd2, OP_SUB, 4'd5, 1'b1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
